// File: rtl/fetch_pc_unit_pkg.sv
// Shared RV32I types for the fetch stage: machine word, fetch FSM encoding and
// PC alignment helpers.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        FETCH_GAP    = 2'd0,
        FETCH_REQ    = 2'd1,
        FETCH_SQUASH = 2'd2
    } fetch_state_t;

    localparam rv32i_word INSTR_BYTES   = 32'd4;
    localparam rv32i_word PC_ALIGN_MASK = 32'hFFFF_FFFC;

    // Instructions are word aligned; the low two bits of a target are discarded.
    function automatic rv32i_word align_pc(input rv32i_word target);
        return target & PC_ALIGN_MASK;
    endfunction

    function automatic logic is_misaligned(input rv32i_word target);
        return target[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_out_buffer.sv
// One-entry holding register between instruction fetch and decode.
// Handshake: an entry transfers on any rising clk edge where valid && ready are both
// high; while valid && !ready the pc/instr fields hold, and flush empties the entry.
module fetch_out_buffer
    import rv32i_types::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      load,
    input  rv32i_word load_pc,
    input  rv32i_word load_instr,
    input  logic      ready,
    output logic      valid,
    output rv32i_word pc,
    output rv32i_word instr
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Architectural PC owner and instruction-memory request engine for the RV32I core;
// redirects squash any stale fetch and the captured instruction is held for decode.
module fetch_pc_unit
    import rv32i_types::*;
#(
    parameter rv32i_word RESET_PC = 32'h0000_0060
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         redirect_valid,
    input  rv32i_word    redirect_target,
    output logic         imem_read,
    output rv32i_word    imem_address,
    input  logic         imem_resp,
    input  rv32i_word    imem_rdata,
    output logic         if_valid,
    input  logic         if_ready,
    output rv32i_word    if_pc,
    output rv32i_word    if_instr,
    output logic         misalign_err,
    output fetch_state_t fsm_state
);

    fetch_state_t state;
    rv32i_word    pc;
    rv32i_word    squash_addr;
    logic         start_fetch;
    logic         capture;

    // A new request is only launched when the buffer will have room for its result.
    assign start_fetch = !if_valid || if_ready || redirect_valid;
    assign capture     = (state == FETCH_REQ) && imem_resp && !redirect_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= FETCH_GAP;
            pc           <= RESET_PC;
            squash_addr  <= '0;
            misalign_err <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pc <= align_pc(redirect_target);
                if (is_misaligned(redirect_target)) begin
                    misalign_err <= 1'b1;
                end
            end
            case (state)
                FETCH_GAP: begin
                    if (start_fetch) begin
                        state <= FETCH_REQ;
                    end
                end
                FETCH_REQ: begin
                    if (imem_resp) begin
                        state <= FETCH_GAP;
                        if (!redirect_valid) begin
                            pc <= pc + INSTR_BYTES;
                        end
                    end else if (redirect_valid) begin
                        // Memory still owes us this word; keep presenting its address.
                        state       <= FETCH_SQUASH;
                        squash_addr <= pc;
                    end
                end
                FETCH_SQUASH: begin
                    if (imem_resp) begin
                        state <= FETCH_GAP;
                    end
                end
                default: state <= FETCH_GAP;
            endcase
        end
    end

    always_comb begin
        imem_read    = 1'b0;
        imem_address = '0;
        case (state)
            FETCH_REQ: begin
                imem_read    = 1'b1;
                imem_address = pc;
            end
            FETCH_SQUASH: begin
                imem_read    = 1'b1;
                imem_address = squash_addr;
            end
            default: begin
                imem_read    = 1'b0;
                imem_address = '0;
            end
        endcase
    end

    assign fsm_state = state;

    fetch_out_buffer u_out_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .load       (capture),
        .load_pc    (pc),
        .load_instr (imem_rdata),
        .ready      (if_ready),
        .valid      (if_valid),
        .pc         (if_pc),
        .instr      (if_instr)
    );

endmodule
